life_event_arbiter: RTL and testbench

Sits between collision detection/level timer and the life counter. Captures the gameplay events that change the life count: heart pickup, obstacle hit, covid hit, time-up and level-up. Serialises them into single-cycle, spaced pulses so the life counter never sees two events in one cycle. Also enforces a frame-counted invulnerability window after every life loss and drives the life counter's enable.

---
 rtl/life_pkg.sv | 31 +++
 rtl/rise_detect.sv | 19 +
 rtl/life_event_arbiter.sv | 137 +++++++++++++
 tb/tb_life_event_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and constants for the life event arbiter: FSM states,
// pending-bit indices and default timing parameters.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int PEND_W  = 4;
  localparam int P_HEART = 0;
  localparam int P_HIT   = 1;
  localparam int P_TIME  = 2;
  localparam int P_LEVEL = 3;

  localparam int DEF_COOLDOWN_FRAMES = 60;
  localparam int DEF_GAP_CYCLES      = 2;
  localparam int GAP_W               = 3;

  // One-hot of the highest-priority pending bit: level > time > hit > heart.
  function automatic logic [PEND_W-1:0] pick_highest(input logic [PEND_W-1:0] p);
    pick_highest = '0;
    if (p[P_LEVEL])      pick_highest[P_LEVEL] = 1'b1;
    else if (p[P_TIME])  pick_highest[P_TIME]  = 1'b1;
    else if (p[P_HIT])   pick_highest[P_HIT]   = 1'b1;
    else if (p[P_HEART]) pick_highest[P_HEART] = 1'b1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the previous sample, flags in & ~prev.
// prev resets to 0 so an input already high at reset release counts as an edge.
module rise_detect (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) prev <= 1'b0;
    else         prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/life_event_arbiter.sv
// Serialises gameplay events into spaced single-cycle pulses for the life
// counter and runs the post-loss invulnerability cooldown.
module life_event_arbiter
  import life_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int CNT_W           = 7
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              SHP_bumpyHeart,
  input  logic              SHP_bumpyObstacle,
  input  logic              SHP_bumpyCovid,
  input  logic              timeUp,
  input  logic              levelUp,
  input  logic              pause,
  input  logic              gameOver,
  output logic              lossPulse,
  output logic              gainPulse,
  output logic              levelUpPulse,
  output logic              lifeEnable,
  output logic              invulnerable,
  output state_t            dbg_state,
  output logic [PEND_W-1:0] dbg_pending
);

  // Output pulses are fire-and-forget strobes: the life counter has no ready,
  // so spacing is guaranteed here by the GAP state instead of back-pressure.

  logic heart_rise, obst_rise, covid_rise, time_rise, level_rise;

  rise_detect u_rd_heart (.clk(clk), .resetN(resetN), .in(SHP_bumpyHeart),    .rise(heart_rise));
  rise_detect u_rd_obst  (.clk(clk), .resetN(resetN), .in(SHP_bumpyObstacle), .rise(obst_rise));
  rise_detect u_rd_covid (.clk(clk), .resetN(resetN), .in(SHP_bumpyCovid),    .rise(covid_rise));
  rise_detect u_rd_time  (.clk(clk), .resetN(resetN), .in(timeUp),            .rise(time_rise));
  rise_detect u_rd_level (.clk(clk), .resetN(resetN), .in(levelUp),           .rise(level_rise));

  state_t             state;
  logic [PEND_W-1:0]  pending;
  logic [GAP_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]   cool_cnt;

  logic [PEND_W-1:0]  set_vec;
  logic [PEND_W-1:0]  clr_vec;
  logic [PEND_W-1:0]  grant;
  logic               issue_now;
  logic               loss_now;

  always_comb begin
    set_vec          = '0;
    set_vec[P_LEVEL] = level_rise;
    set_vec[P_TIME]  = time_rise;
    set_vec[P_HIT]   = (obst_rise | covid_rise) & ~invulnerable;
    set_vec[P_HEART] = heart_rise;

    grant     = pick_highest(pending);
    issue_now = (state == IDLE) && (|pending) && !pause && !gameOver;
    loss_now  = issue_now && (grant[P_TIME] || grant[P_HIT]);

    clr_vec = '0;
    if (issue_now) begin
      clr_vec = grant;
      // A level change makes any queued hit stale.
      if (grant[P_LEVEL]) clr_vec[P_HIT] = 1'b1;
    end
  end

  // The IDLE cycle itself is the last idle cycle of the gap, so GAP only
  // needs GAP_CYCLES-1 cycles of its own.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      pending      <= '0;
      gap_cnt      <= '0;
      lossPulse    <= 1'b0;
      gainPulse    <= 1'b0;
      levelUpPulse <= 1'b0;
      lifeEnable   <= 1'b0;
    end else begin
      lossPulse    <= 1'b0;
      gainPulse    <= 1'b0;
      levelUpPulse <= 1'b0;
      lifeEnable   <= !pause && !gameOver && (state != OVER);
      if (gameOver || state == OVER) begin
        state   <= OVER;
        pending <= '0;
      end else begin
        pending <= (pending & ~clr_vec) | set_vec;
        case (state)
          IDLE: begin
            if (issue_now) begin
              state        <= ISSUE;
              levelUpPulse <= grant[P_LEVEL];
              lossPulse    <= grant[P_TIME] | grant[P_HIT];
              gainPulse    <= grant[P_HEART];
            end
          end
          ISSUE: begin
            if (GAP_CYCLES > 1) begin
              state   <= GAP;
              gap_cnt <= GAP_W'(GAP_CYCLES - 2);
            end else begin
              state <= IDLE;
            end
          end
          GAP: begin
            if (!pause) begin
              if (gap_cnt == '0) state <= IDLE;
              else               gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Load wins over decrement; invulnerable trails the counter by one cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cool_cnt     <= '0;
      invulnerable <= 1'b0;
    end else begin
      if (loss_now)
        cool_cnt <= CNT_W'(COOLDOWN_FRAMES);
      else if (startOfFrame && cool_cnt != '0 && !pause)
        cool_cnt <= cool_cnt - 1'b1;
      invulnerable <= (cool_cnt != '0);
    end
  end

  assign dbg_state   = state;
  assign dbg_pending = pending;

endmodule

// File: tb/tb_life_event_arbiter.sv
// Directed bench for life_event_arbiter: each scenario task drives stimulus
// and compares outputs against hand-derived cycle-accurate expectations.
module tb_life_event_arbiter;
  import life_pkg::*;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic heart = 1'b0, obstacle = 1'b0, covid = 1'b0;
  logic timeUp = 1'b0, levelUp = 1'b0, pause = 1'b0, gameOver = 1'b0;
  logic lossPulse, gainPulse, levelUpPulse, lifeEnable, invulnerable;
  state_t dbg_state;
  logic [PEND_W-1:0] dbg_pending;

  always #5 clk = ~clk;

  life_event_arbiter dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .SHP_bumpyHeart(heart), .SHP_bumpyObstacle(obstacle), .SHP_bumpyCovid(covid),
    .timeUp(timeUp), .levelUp(levelUp), .pause(pause), .gameOver(gameOver),
    .lossPulse(lossPulse), .gainPulse(gainPulse), .levelUpPulse(levelUpPulse),
    .lifeEnable(lifeEnable), .invulnerable(invulnerable),
    .dbg_state(dbg_state), .dbg_pending(dbg_pending)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int multi_cnt = 0;
  int ev_kind[$];   // 0 = level-up, 1 = loss, 2 = gain
  int ev_cyc[$];

  // Advance n cycles, sampling 1 ns after each rising edge and logging pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (int'(lossPulse) + int'(gainPulse) + int'(levelUpPulse) > 1) multi_cnt++;
      if (levelUpPulse) begin ev_kind.push_back(0); ev_cyc.push_back(cyc); end
      if (lossPulse)    begin ev_kind.push_back(1); ev_cyc.push_back(cyc); end
      if (gainPulse)    begin ev_kind.push_back(2); ev_cyc.push_back(cyc); end
    end
  endtask

  task automatic clear_log();
    ev_kind.delete();
    ev_cyc.delete();
  endtask

  function automatic int count_kind(input int k);
    int c = 0;
    foreach (ev_kind[i]) if (ev_kind[i] == k) c++;
    return c;
  endfunction

  task automatic frames(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      step(1);
      startOfFrame = 1'b0;
      step(period - 1);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    step(2);
    total_cnt++;
    if ({lossPulse, gainPulse, levelUpPulse} !== 3'b000) $display("FAIL reset_pulses got=%b exp=000", {lossPulse, gainPulse, levelUpPulse});
    else pass_cnt++;
    total_cnt++;
    if ({invulnerable, lifeEnable} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {invulnerable, lifeEnable});
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== IDLE || dbg_pending !== 4'b0000) $display("FAIL reset_state got=%0d/%b exp=IDLE/0000", dbg_state, dbg_pending);
    else pass_cnt++;
    resetN = 1'b1;
    step(1);
    total_cnt++;
    if (lifeEnable !== 1'b1) $display("FAIL reset_release_enable got=%b exp=1", lifeEnable);
    else pass_cnt++;
  endtask

  task automatic test_obstacle_hold();
    logic [PEND_W-1:0] exp_p;
    int c0;
    clear_log();
    c0 = cyc;
    obstacle = 1'b1;
    step(1);
    exp_p = '0;
    exp_p[P_HIT] = 1'b1;
    total_cnt++;
    if (dbg_pending !== exp_p) $display("FAIL hit_pending got=%b exp=%b", dbg_pending, exp_p);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (lossPulse !== 1'b1 || cyc != c0 + 2) $display("FAIL hit_latency got=%b@%0d exp=1@%0d", lossPulse, cyc, c0 + 2);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (invulnerable !== 1'b1) $display("FAIL hit_invuln_rise got=%b exp=1", invulnerable);
    else pass_cnt++;
    step(497);
    total_cnt++;
    if (count_kind(1) != 1 || ev_kind.size() != 1) $display("FAIL hold_single_loss got=%0d/%0d exp=1/1", count_kind(1), ev_kind.size());
    else pass_cnt++;
    obstacle = 1'b0;
    step(1);
  endtask

  task automatic test_cooldown_covid();
    clear_log();
    frames(10, 4);
    covid = 1'b1;
    step(1);
    total_cnt++;
    if (dbg_pending !== 4'b0000) $display("FAIL covid_discard_pending got=%b exp=0000", dbg_pending);
    else pass_cnt++;
    step(4);
    total_cnt++;
    if (count_kind(1) != 0) $display("FAIL covid_no_loss got=%0d exp=0", count_kind(1));
    else pass_cnt++;
    covid = 1'b0;
    pause = 1'b1;
    frames(3, 4);
    pause = 1'b0;
    step(1);
    frames(49, 4);
    total_cnt++;
    if (invulnerable !== 1'b1) $display("FAIL cooldown_frame59 got=%b exp=1", invulnerable);
    else pass_cnt++;
    startOfFrame = 1'b1;
    step(1);
    startOfFrame = 1'b0;
    total_cnt++;
    if (invulnerable !== 1'b1) $display("FAIL cooldown_frame60_lag got=%b exp=1", invulnerable);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (invulnerable !== 1'b0) $display("FAIL cooldown_expire got=%b exp=0", invulnerable);
    else pass_cnt++;
  endtask

  task automatic test_level_hit();
    clear_log();
    levelUp = 1'b1;
    obstacle = 1'b1;
    step(2);
    total_cnt++;
    if (levelUpPulse !== 1'b1 || dbg_pending !== 4'b0000) $display("FAIL level_hit_issue got=%b/%b exp=1/0000", levelUpPulse, dbg_pending);
    else pass_cnt++;
    step(10);
    total_cnt++;
    if (count_kind(1) != 0 || count_kind(0) != 1) $display("FAIL level_hit_no_loss got=%0d/%0d exp=0/1", count_kind(1), count_kind(0));
    else pass_cnt++;
    levelUp = 1'b0;
    obstacle = 1'b0;
    step(2);
  endtask

  task automatic test_back_to_back();
    int c0;
    logic ok;
    clear_log();
    c0 = cyc;
    levelUp = 1'b1;
    timeUp = 1'b1;
    heart = 1'b1;
    step(12);
    ok = (ev_kind.size() == 3) && (ev_kind[0] == 0) && (ev_kind[1] == 1) && (ev_kind[2] == 2);
    total_cnt++;
    if (!ok) $display("FAIL b2b_order got_count=%0d exp=3 in order level,loss,gain", ev_kind.size());
    else pass_cnt++;
    ok = (ev_cyc.size() == 3) && (ev_cyc[0] == c0 + 2) && (ev_cyc[1] == c0 + 5) && (ev_cyc[2] == c0 + 8);
    total_cnt++;
    if (!ok) $display("FAIL b2b_spacing got_first=%0d exp=%0d,%0d,%0d", (ev_cyc.size() > 0) ? ev_cyc[0] : -1, c0 + 2, c0 + 5, c0 + 8);
    else pass_cnt++;
    levelUp = 1'b0;
    timeUp = 1'b0;
    heart = 1'b0;
    step(2);
  endtask

  task automatic test_pause_heart();
    logic [PEND_W-1:0] exp_p;
    clear_log();
    pause = 1'b1;
    heart = 1'b1;
    step(6);
    exp_p = '0;
    exp_p[P_HEART] = 1'b1;
    total_cnt++;
    if (count_kind(2) != 0 || dbg_pending !== exp_p) $display("FAIL pause_hold got=%0d/%b exp=0/%b", count_kind(2), dbg_pending, exp_p);
    else pass_cnt++;
    total_cnt++;
    if (lifeEnable !== 1'b0) $display("FAIL pause_enable got=%b exp=0", lifeEnable);
    else pass_cnt++;
    pause = 1'b0;
    step(1);
    total_cnt++;
    if (gainPulse !== 1'b1) $display("FAIL pause_release_gain got=%b exp=1", gainPulse);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (dbg_pending !== 4'b0000 || lifeEnable !== 1'b1) $display("FAIL pause_release_state got=%b/%b exp=0000/1", dbg_pending, lifeEnable);
    else pass_cnt++;
    heart = 1'b0;
    step(4);
  endtask

  task automatic test_game_over();
    clear_log();
    levelUp = 1'b1;
    timeUp = 1'b1;
    step(2);
    total_cnt++;
    if (levelUpPulse !== 1'b1) $display("FAIL over_pre_level got=%b exp=1", levelUpPulse);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (dbg_state !== GAP) $display("FAIL over_in_gap got=%0d exp=%0d", dbg_state, GAP);
    else pass_cnt++;
    gameOver = 1'b1;
    step(1);
    total_cnt++;
    if (dbg_state !== OVER || dbg_pending !== 4'b0000 || lifeEnable !== 1'b0)
      $display("FAIL over_enter got=%0d/%b/%b exp=%0d/0000/0", dbg_state, dbg_pending, lifeEnable, OVER);
    else pass_cnt++;
    levelUp = 1'b0;
    timeUp = 1'b0;
    gameOver = 1'b0;
    step(3);
    heart = 1'b1;
    step(6);
    total_cnt++;
    if (ev_kind.size() != 1 || dbg_state !== OVER) $display("FAIL over_sticky got=%0d/%0d exp=1/%0d", ev_kind.size(), dbg_state, OVER);
    else pass_cnt++;
    resetN = 1'b0;
    #1;
    total_cnt++;
    if (dbg_state !== IDLE || invulnerable !== 1'b0 || lifeEnable !== 1'b0 || dbg_pending !== 4'b0000)
      $display("FAIL async_reset got=%0d/%b/%b/%b exp=IDLE/0/0/0000", dbg_state, invulnerable, lifeEnable, dbg_pending);
    else pass_cnt++;
    step(2);
    resetN = 1'b1;
    clear_log();
    step(2);
    total_cnt++;
    if (gainPulse !== 1'b1) $display("FAIL reset_held_input_edge got=%b exp=1", gainPulse);
    else pass_cnt++;
    heart = 1'b0;
    step(4);
  endtask

  initial begin
    test_reset();
    test_obstacle_hold();
    test_cooldown_covid();
    test_level_hit();
    test_back_to_back();
    test_pause_heart();
    test_game_over();
    total_cnt++;
    if (multi_cnt != 0) $display("FAIL one_pulse_per_cycle got=%0d exp=0", multi_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
